pool_win_addr_gen: RTL

Upstream address generator for the max/avg pool datapath. It walks every output pixel and every KxK window tap, and drives (row, image width) into the pooling 16x8 unsigned pipelined multiplier. It aligns the column offset and control flags with the multiplier's 3-cycle latency and emits a flat feature-map read address, address = row*IMG_W + col, with a valid/ready handshake toward the line-buffer read port.

---
 rtl/pool_pkg.sv | 30 +++
 rtl/pool_delay_line.sv | 53 +++++
 rtl/pool_win_addr_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
`default_nettype none
//==============================================================================
// Module   : pool_pkg
// Brief    : Shared types, widths and output-dimension helpers for the pool
//            window address generator.
// Revision : 1.0 - initial release
//==============================================================================
package pool_pkg;

    localparam int ADDR_W = 16;
    localparam int DIM_W  = 8;
    localparam int ROW_W  = 10;
    localparam int K_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int out_h(input int img_h, input int k, input int s);
        return (img_h - k) / s + 1;
    endfunction

    function automatic int out_w(input int img_w, input int k, input int s);
        return (img_w - k) / s + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_delay_line.sv
`default_nettype none
//==============================================================================
// Module   : pool_delay_line
// Brief    : DEPTH-stage enabled shift register carrying {valid, col, last}
//            in lockstep with the multiplier pipeline.
// Revision : 1.0 - initial release
//==============================================================================
module pool_delay_line #(
    parameter int DEPTH = 3,
    parameter int COL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [COL_W-1:0] i_col,
    input  logic             i_last,
    output logic             o_valid,
    output logic [COL_W-1:0] o_col,
    output logic             o_last,
    output logic             o_empty
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_last;
    logic [COL_W-1:0] r_col [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_last  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_col[i] <= '0;
            end
        end else if (i_en) begin
            r_valid[0] <= i_valid;
            r_last[0]  <= i_last;
            r_col[0]   <= i_col;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_last[i]  <= r_last[i-1];
                r_col[i]   <= r_col[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_last  = r_last[DEPTH-1];
    assign o_col   = r_col[DEPTH-1];
    assign o_empty = ~|r_valid;

endmodule
`default_nettype wire

// File: rtl/pool_win_addr_gen.sv
`default_nettype none
//==============================================================================
// Module   : pool_win_addr_gen
// Brief    : Walks output pixels and KxK taps, drives row*IMG_W through the
//            external multiplier and emits addr = row*IMG_W + col.
// Revision : 1.0 - initial release
//==============================================================================
module pool_win_addr_gen
    import pool_pkg::*;
#(
    parameter int IMG_W   = 24,
    parameter int IMG_H   = 24,
    parameter int POOL_K  = 2,
    parameter int STRIDE  = 2,
    parameter int MUL_LAT = 3
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] mul_din0,
    output logic [DIM_W-1:0]  mul_din1,
    output logic              mul_ce,
    input  logic [ADDR_W-1:0] mul_dout,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              win_last,
    output logic              frame_done
);

    localparam int c_out_h = out_h(IMG_H, POOL_K, STRIDE);
    localparam int c_out_w = out_w(IMG_W, POOL_K, STRIDE);

    state_t            r_state;
    state_t            w_state_next;
    logic [ROW_W-1:0]  r_oy;
    logic [DIM_W-1:0]  r_ox;
    logic [K_W-1:0]    r_ky;
    logic [K_W-1:0]    r_kx;

    logic              w_adv;
    logic              w_issue;
    logic              w_done;
    logic              w_kx_wrap;
    logic              w_ky_wrap;
    logic              w_ox_wrap;
    logic              w_oy_wrap;
    logic              w_last;
    logic              w_final;
    logic [ADDR_W-1:0] w_row;
    logic [DIM_W-1:0]  w_col;

    logic              w_dl_valid;
    logic              w_dl_last;
    logic              w_dl_empty;
    logic [DIM_W-1:0]  w_dl_col;

    logic [ADDR_W-1:0] r_addr;
    logic              r_addr_valid;
    logic              r_win_last;
    logic              r_frame_done;

    // The whole pipeline, multiplier included, moves only when the output
    // register is free or being drained this cycle.
    assign w_adv = !r_addr_valid || addr_ready;

    assign w_kx_wrap = (r_kx == K_W'(POOL_K - 1));
    assign w_ky_wrap = (r_ky == K_W'(POOL_K - 1));
    assign w_ox_wrap = (r_ox == DIM_W'(c_out_w - 1));
    assign w_oy_wrap = (r_oy == ROW_W'(c_out_h - 1));
    assign w_last    = w_ky_wrap && w_kx_wrap;
    assign w_final   = w_oy_wrap && w_ox_wrap && w_last;

    assign w_row = ADDR_W'(r_oy) * ADDR_W'(STRIDE) + ADDR_W'(r_ky);
    assign w_col = r_ox * DIM_W'(STRIDE) + DIM_W'(r_kx);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_issue = 1'b1;
                if (w_adv && w_final) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_dl_empty && w_adv) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Tap counters, kx innermost; each wraps at its limit.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_oy <= '0;
            r_ox <= '0;
            r_ky <= '0;
            r_kx <= '0;
        end else if (r_state == IDLE && start) begin
            r_oy <= '0;
            r_ox <= '0;
            r_ky <= '0;
            r_kx <= '0;
        end else if (w_issue && w_adv) begin
            r_kx <= w_kx_wrap ? '0 : r_kx + K_W'(1);
            if (w_kx_wrap) begin
                r_ky <= w_ky_wrap ? '0 : r_ky + K_W'(1);
                if (w_ky_wrap) begin
                    r_ox <= w_ox_wrap ? '0 : r_ox + DIM_W'(1);
                    if (w_ox_wrap) begin
                        r_oy <= w_oy_wrap ? '0 : r_oy + ROW_W'(1);
                    end
                end
            end
        end
    end

    pool_delay_line #(
        .DEPTH (MUL_LAT),
        .COL_W (DIM_W)
    ) u_delay (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .i_en    (w_adv),
        .i_valid (w_issue),
        .i_col   (w_col),
        .i_last  (w_last),
        .o_valid (w_dl_valid),
        .o_col   (w_dl_col),
        .o_last  (w_dl_last),
        .o_empty (w_dl_empty)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_addr       <= '0;
            r_addr_valid <= 1'b0;
            r_win_last   <= 1'b0;
        end else if (w_adv) begin
            r_addr       <= mul_dout + ADDR_W'(w_dl_col);
            r_addr_valid <= w_dl_valid;
            r_win_last   <= w_dl_last;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_done;
        end
    end

    // Multiplier is idled outside a frame so it is quiet in reset and IDLE.
    assign mul_ce     = w_adv && (r_state != IDLE);
    assign mul_din0   = (r_state == RUN) ? w_row : '0;
    assign mul_din1   = DIM_W'(IMG_W);
    assign busy       = (r_state != IDLE) || r_frame_done;
    assign addr       = r_addr;
    assign addr_valid = r_addr_valid;
    assign win_last   = r_win_last;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
